pll_reset_sequencer: RTL and testbench

- Owns reset and lock supervision of the 4-output system PLL (50/40/25/100 MHz outputs from a 50 MHz refclk).
- Drives the PLL's active-high reset and waits for lock with a timeout and retry.
- Qualifies lock as stable, then releases per-clock-domain resets one at a time.
- Runs entirely on the free-running refclk; each downstream domain re-synchronizes its reset release locally.

---
 rtl/pll_reset_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock supervisor: pulses the PLL reset, qualifies lock, then releases domain resets in order.
// Optional lock-loss counter is built only when PLL_LOCK_LOSS_CNT_EN is defined.
module pll_reset_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 256,
    parameter int RELEASE_GAP   = 4,
    parameter int NUM_DOMAINS   = 4,
    parameter int MAX_RETRIES   = 8
) (
    input  logic                   refclk,
    input  logic                   rst_n,
    input  logic                   pll_locked,
    input  logic                   soft_rst_req,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] domain_rst_n,
    output logic                   ready,
    output logic                   fault,
    output logic [3:0]             retry_cnt,
    output logic [15:0]            lock_loss_cnt
);

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int CNT_MAX = max_of(max_of(LOCK_TIMEOUT, STABLE_CYCLES),
                                    max_of(RST_CYCLES, RELEASE_GAP));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ASSERT_RST,
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN,
        FAULT
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               lock_sync_p0;
    logic               lock_s;
    logic [3:0]         retry_nxt;

    function automatic logic [3:0] retry_inc(input logic [3:0] v);
        return (v >= 4'(MAX_RETRIES)) ? v : v + 4'd1;
    endfunction

    assign retry_nxt = retry_inc(retry_cnt);

    // lock synchronizer: pll_locked is asynchronous to refclk
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lock_sync_p0 <= 1'b0;
            lock_s       <= 1'b0;
        end else begin
            lock_sync_p0 <= pll_locked;
            lock_s       <= lock_sync_p0;
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ASSERT_RST;
            cnt          <= '0;
            pll_rst      <= 1'b1;
            domain_rst_n <= '0;
            ready        <= 1'b0;
            fault        <= 1'b0;
            retry_cnt    <= '0;
        end else if (soft_rst_req) begin
            state        <= ASSERT_RST;
            cnt          <= '0;
            pll_rst      <= 1'b1;
            domain_rst_n <= '0;
            ready        <= 1'b0;
            fault        <= 1'b0;
            retry_cnt    <= '0;
        end else begin
            case (state)
                ASSERT_RST: begin
                    pll_rst      <= 1'b1;
                    domain_rst_n <= '0;
                    if (cnt == CNT_W'(RST_CYCLES - 1)) begin
                        state   <= WAIT_LOCK;
                        cnt     <= '0;
                        pll_rst <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        cnt       <= '0;
                        retry_cnt <= retry_nxt;
                        pll_rst   <= 1'b1;
                        if (retry_nxt == 4'(MAX_RETRIES)) begin
                            state <= FAULT;
                            fault <= 1'b1;
                        end else begin
                            state <= ASSERT_RST;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
                        state     <= RELEASE;
                        cnt       <= '0;
                        retry_cnt <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (!lock_s) begin
                        state        <= ASSERT_RST;
                        cnt          <= '0;
                        pll_rst      <= 1'b1;
                        domain_rst_n <= '0;
                        ready        <= 1'b0;
                    end else if (domain_rst_n[NUM_DOMAINS-1]) begin
                        state <= RUN;
                        cnt   <= '0;
                        ready <= 1'b1;
                    end else if (!domain_rst_n[0] || cnt == CNT_W'(RELEASE_GAP - 1)) begin
                        // shift in a one so bit 0 releases first, then each next bit in turn
                        domain_rst_n <= NUM_DOMAINS'({domain_rst_n, 1'b1});
                        cnt          <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state        <= ASSERT_RST;
                        cnt          <= '0;
                        pll_rst      <= 1'b1;
                        domain_rst_n <= '0;
                        ready        <= 1'b0;
                    end
                end
                FAULT: begin
                    pll_rst      <= 1'b1;
                    domain_rst_n <= '0;
                    fault        <= 1'b1;
                end
                default: begin
                    state <= ASSERT_RST;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef PLL_LOCK_LOSS_CNT_EN
    logic lock_loss_evt;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // a software re-sequence takes priority, so it is never counted as a loss
    assign lock_loss_evt = !soft_rst_req && !lock_s && (state == RUN || state == RELEASE);

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lock_loss_cnt <= '0;
        end else if (lock_loss_evt) begin
            lock_loss_cnt <= sat_inc16(lock_loss_cnt);
        end
    end
`else
    assign lock_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: expected output-change events are queued by the stimulus
// and a monitor pops one each time the DUT output vector changes, checking value and cycle offset.
module tb_pll_reset_sequencer;

    localparam int NUM_DOMAINS = 4;
`ifdef PLL_LOCK_LOSS_CNT_EN
    localparam logic [15:0] LLE = 16'd1;
`else
    localparam logic [15:0] LLE = 16'd0;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   pll_locked;
    logic                   soft_rst_req;
    logic                   pll_rst;
    logic [NUM_DOMAINS-1:0] domain_rst_n;
    logic                   ready;
    logic                   fault;
    logic [3:0]             retry_cnt;
    logic [15:0]            lock_loss_cnt;

    typedef struct {
        int          off;
        logic [26:0] val;
        string       nm;
    } ev_t;

    ev_t q[$];
    int  cyc = 0;
    int  mark = 0;
    int  checks = 0;
    int  passes = 0;

    pll_reset_sequencer #(
        .RST_CYCLES   (16),
        .LOCK_TIMEOUT (100),
        .STABLE_CYCLES(256),
        .RELEASE_GAP  (4),
        .NUM_DOMAINS  (NUM_DOMAINS),
        .MAX_RETRIES  (3)
    ) dut (
        .refclk       (clk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .soft_rst_req (soft_rst_req),
        .pll_rst      (pll_rst),
        .domain_rst_n (domain_rst_n),
        .ready        (ready),
        .fault        (fault),
        .retry_cnt    (retry_cnt),
        .lock_loss_cnt(lock_loss_cnt)
    );

    initial forever #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [26:0] mk(input logic p, input logic f, input logic r,
                                       input logic [3:0] rc, input logic [3:0] d,
                                       input logic [15:0] ll);
        return {p, f, r, rc, d, ll};
    endfunction

    task automatic expect_ev(input int off, input string nm, input logic [26:0] v);
        ev_t e;
        e.off = off;
        e.val = v;
        e.nm  = nm;
        q.push_back(e);
    endtask

    task automatic wait_to(input int off);
        while (cyc - mark < off) @(negedge clk);
    endtask

    // monitor: every change of the output vector consumes one expected event
    initial begin
        logic [26:0] snap;
        logic [26:0] prev;
        bit          first;
        ev_t         e;
        int          off;
        first = 1'b1;
        prev  = '0;
        forever begin
            @(negedge clk);
            snap = {pll_rst, fault, ready, retry_cnt, domain_rst_n, lock_loss_cnt};
            off  = cyc - mark;
            if (first || snap !== prev) begin
                checks++;
                if (q.size() == 0) begin
                    $display("FAIL unexpected_change: got %h @%0d, expected no change", snap, off);
                end else begin
                    e = q.pop_front();
                    if (snap !== e.val || (e.off >= 0 && off != e.off))
                        $display("FAIL %s: got %h @%0d, expected %h @%0d", e.nm, snap, off, e.val, e.off);
                    else
                        passes++;
                end
            end
            first = 1'b0;
            prev  = snap;
        end
    end

    initial begin
        rst_n        = 1'b1;
        pll_locked   = 1'b0;
        soft_rst_req = 1'b0;
        #1 rst_n = 1'b0;
        expect_ev(-1, "reset_state", mk(1, 0, 0, 0, 4'h0, 0));
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        mark  = cyc;

        // nominal bring-up: lock at +100, seen at +103, release starts +359
        expect_ev(16,  "pll_rst_fall",  mk(0, 0, 0, 0, 4'h0, 0));
        expect_ev(360, "dom_0001",      mk(0, 0, 0, 0, 4'h1, 0));
        expect_ev(364, "dom_0011",      mk(0, 0, 0, 0, 4'h3, 0));
        expect_ev(368, "dom_0111",      mk(0, 0, 0, 0, 4'h7, 0));
        expect_ev(372, "dom_1111",      mk(0, 0, 0, 0, 4'hF, 0));
        expect_ev(373, "ready_rise",    mk(0, 0, 1, 0, 4'hF, 0));
        wait_to(100);
        pll_locked = 1'b1;

        // lock loss in RUN, then the full sequence repeats
        wait_to(380);
        pll_locked = 1'b0;
        expect_ev(383, "run_loss",      mk(1, 0, 0, 0, 4'h0, LLE));
        expect_ev(399, "rerun_pll_fall", mk(0, 0, 0, 0, 4'h0, LLE));
        expect_ev(657, "rerun_0001",    mk(0, 0, 0, 0, 4'h1, LLE));
        expect_ev(661, "rerun_0011",    mk(0, 0, 0, 0, 4'h3, LLE));
        wait_to(383);
        pll_locked = 1'b1;

        // lock loss in RELEASE, then lock stays low: three timeouts into FAULT
        wait_to(662);
        pll_locked = 1'b0;
        expect_ev(665,  "release_loss", mk(1, 0, 0, 0, 4'h0, 2*LLE));
        expect_ev(681,  "wait_a",       mk(0, 0, 0, 0, 4'h0, 2*LLE));
        expect_ev(781,  "timeout_1",    mk(1, 0, 0, 1, 4'h0, 2*LLE));
        expect_ev(797,  "wait_b",       mk(0, 0, 0, 1, 4'h0, 2*LLE));
        expect_ev(897,  "timeout_2",    mk(1, 0, 0, 2, 4'h0, 2*LLE));
        expect_ev(913,  "wait_c",       mk(0, 0, 0, 2, 4'h0, 2*LLE));
        expect_ev(1013, "fault",        mk(1, 1, 0, 3, 4'h0, 2*LLE));

        // soft request exits FAULT
        wait_to(1030);
        soft_rst_req = 1'b1;
        expect_ev(1031, "soft_clear",   mk(1, 0, 0, 0, 4'h0, 2*LLE));
        expect_ev(1047, "soft_pll_fall", mk(0, 0, 0, 0, 4'h0, 2*LLE));
        wait_to(1031);
        soft_rst_req = 1'b0;

        // soft request on the timeout edge wins, then restarts the count inside ASSERT_RST
        wait_to(1146);
        soft_rst_req = 1'b1;
        expect_ev(1147, "soft_vs_timeout", mk(1, 0, 0, 0, 4'h0, 2*LLE));
        expect_ev(1167, "soft_restart",    mk(0, 0, 0, 0, 4'h0, 2*LLE));
        wait_to(1147);
        soft_rst_req = 1'b0;
        wait_to(1150);
        soft_rst_req = 1'b1;
        wait_to(1151);
        soft_rst_req = 1'b0;

        // one-cycle glitch at stable count 200 restarts qualification
        wait_to(1170);
        pll_locked = 1'b1;
        expect_ev(1632, "glitch_0001",  mk(0, 0, 0, 0, 4'h1, 2*LLE));
        expect_ev(1636, "glitch_0011",  mk(0, 0, 0, 0, 4'h3, 2*LLE));
        wait_to(1371);
        pll_locked = 1'b0;
        wait_to(1372);
        pll_locked = 1'b1;

        // rst_n mid-RELEASE, asserted just after a rising edge
        wait_to(1637);
        expect_ev(1638, "async_reset",  mk(1, 0, 0, 0, 4'h0, 0));
        @(posedge clk);
        #2 rst_n = 1'b0;
        wait_to(1645);
        rst_n = 1'b1;
        expect_ev(1661, "post_reset_pll_fall", mk(0, 0, 0, 0, 4'h0, 0));
        wait_to(1680);

        checks++;
        if (q.size() != 0)
            $display("FAIL missing_events: got %0d events still pending, expected 0", q.size());
        else
            passes++;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
